crm_diag_seq: RTL and testbench

Diagnostic sequencer for the control RAM (CRAM). It takes one request at a time: write a full 84-bit microword at an 11-bit CRAM address, read one back, or write one and read it back to verify. It turns each request into the correct series of DIAG LOAD FUNC 05x and DIAG READ FUNC 14x bus transactions toward the CRM boards. It sits between the console/diagnostic front end and the CRM board slices, and is the only master of the CRAM diag function strobes.

---
 rtl/crm_diag_seq.sv | 195 +++++++++++++++++++
 tb/tb_crm_diag_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crm_diag_seq.sv
// crm_diag_seq -- CRAM diagnostic sequencer.
//
// Takes one request at a time and turns it into DIAG LOAD FUNC 05x /
// DIAG READ FUNC 14x bus transactions toward the CRM board slices:
//   op 00  load     : ADR(func 7), WR slices 0..N_SLICES-1
//   op 01  read     : ADR(func 7), RD slices 0..N_SLICES-1
//   op 10  load+vfy : ADR, WR slices, ADR, RD slices, CMP
//   op 11  reserved : behaves as read
// Each transaction holds the strobe for HOLD_CYC cycles, then one gap
// cycle with both strobes low.  diag_func_h and ebus_out_h stay stable
// for the whole transaction, gap included.
//
// Handshake: req_h is a request qualified only while the sequencer is
// idle (busy_h low and done_h low).  A request seen in IDLE is accepted
// on that edge; busy_h rises the next cycle and stays high until the
// sequencer returns to IDLE.  Requests while busy are dropped, not queued.
// done_h pulses for one cycle; rdata_h and err_h are valid with it and
// hold until the next accept.
//
// Ports:
//   clk_crm_00_h        clock, rising edge
//   mr_reset_01_h       synchronous active-high reset
//   req_h, op_h, adr_h, wdata_h      request and its operands
//   busy_h, done_h, err_h, rdata_h   status and read-back result
//   diag_load_strobe_h, diag_read_strobe_h, diag_func_h   diag bus control
//   ebus_out_h, ebus_in_h            diag bus data
//   state_dbg           current FSM state (debug visibility)

module crm_diag_seq #(
  parameter int WORD_W   = 84,
  parameter int SLICE_W  = 12,
  parameter int N_SLICES = 7,
  parameter int HOLD_CYC = 2
) (
  input  logic               clk_crm_00_h,
  input  logic               mr_reset_01_h,
  input  logic               req_h,
  input  logic [1:0]         op_h,
  input  logic [10:0]        adr_h,
  input  logic [WORD_W-1:0]  wdata_h,
  output logic               busy_h,
  output logic               done_h,
  output logic               err_h,
  output logic [WORD_W-1:0]  rdata_h,
  output logic               diag_load_strobe_h,
  output logic               diag_read_strobe_h,
  output logic [2:0]         diag_func_h,
  output logic [SLICE_W-1:0] ebus_out_h,
  input  logic [SLICE_W-1:0] ebus_in_h,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADR  = 3'd1,
    S_WR   = 3'd2,
    S_RD   = 3'd3,
    S_CMP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);
  localparam logic [3:0] GAP_CYC    = 4'(HOLD_CYC);
  localparam logic [2:0] LAST_SLICE = 3'(N_SLICES - 1);
  localparam logic [2:0] FUNC_ADR   = 3'd7;

  state_t              state;
  logic [1:0]          op_q;
  logic [10:0]         adr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                verify;   // set after the write pass of a load+verify
  logic [2:0]          slice;
  logic [3:0]          cyc;      // position inside the current transaction

  assign state_dbg = state;

  always_ff @(posedge clk_crm_00_h) begin
    if (mr_reset_01_h) begin
      state              <= S_IDLE;
      op_q               <= '0;
      adr_q              <= '0;
      wdata_q            <= '0;
      verify             <= 1'b0;
      slice              <= '0;
      cyc                <= '0;
      busy_h             <= 1'b0;
      done_h             <= 1'b0;
      err_h              <= 1'b0;
      rdata_h            <= '0;
      diag_load_strobe_h <= 1'b0;
      diag_read_strobe_h <= 1'b0;
      diag_func_h        <= '0;
      ebus_out_h         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_h) begin
            op_q               <= op_h;
            adr_q              <= adr_h;
            wdata_q            <= wdata_h;
            err_h              <= 1'b0;
            rdata_h            <= '0;
            verify             <= 1'b0;
            slice              <= '0;
            cyc                <= '0;
            busy_h             <= 1'b1;
            state              <= S_ADR;
            // The address transaction starts in the very next cycle.
            diag_load_strobe_h <= 1'b1;
            diag_func_h        <= FUNC_ADR;
            ebus_out_h         <= SLICE_W'(adr_h);
          end
        end

        S_ADR, S_WR, S_RD: begin
          if (cyc == GAP_CYC) begin
            // Gap cycle: end of this transaction, set up the next one so
            // its strobe is visible in the following cycle.
            cyc <= '0;
            if (state == S_ADR) begin
              // ops 00 and 10 have bit 0 clear; the verify flag turns the
              // second address pass of a load+verify into a read.
              if (!verify && !op_q[0]) begin
                state              <= S_WR;
                diag_load_strobe_h <= 1'b1;
                diag_func_h        <= 3'd0;
                ebus_out_h         <= wdata_q[SLICE_W-1:0];
              end else begin
                state              <= S_RD;
                diag_read_strobe_h <= 1'b1;
                diag_func_h        <= 3'd0;
                ebus_out_h         <= '0;
              end
            end else if (slice != LAST_SLICE) begin
              slice       <= slice + 3'd1;
              diag_func_h <= slice + 3'd1;
              if (state == S_WR) begin
                diag_load_strobe_h <= 1'b1;
                ebus_out_h         <= wdata_q[SLICE_W*(slice+3'd1) +: SLICE_W];
              end else begin
                diag_read_strobe_h <= 1'b1;
              end
            end else begin
              slice <= '0;
              if (state == S_WR && op_q == 2'b10) begin
                state              <= S_ADR;
                verify             <= 1'b1;
                diag_load_strobe_h <= 1'b1;
                diag_func_h        <= FUNC_ADR;
                ebus_out_h         <= SLICE_W'(adr_q);
              end else if (state == S_RD && op_q == 2'b10) begin
                state       <= S_CMP;
                diag_func_h <= '0;
                ebus_out_h  <= '0;
              end else begin
                state       <= S_DONE;
                done_h      <= 1'b1;
                diag_func_h <= '0;
                ebus_out_h  <= '0;
              end
            end
          end else begin
            if (cyc == HOLD_LAST) begin
              // Last strobe cycle: drop the strobe for the gap and, on a
              // read, take the slice the board is returning now.
              diag_load_strobe_h <= 1'b0;
              diag_read_strobe_h <= 1'b0;
              if (state == S_RD) begin
                rdata_h[SLICE_W*slice +: SLICE_W] <= ebus_in_h;
              end
            end
            cyc <= cyc + 4'd1;
          end
        end

        S_CMP: begin
          err_h  <= (rdata_h != wdata_q);
          done_h <= 1'b1;
          state  <= S_DONE;
        end

        S_DONE: begin
          done_h <= 1'b0;
          busy_h <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crm_diag_seq.sv
// tb_crm_diag_seq -- self-checking bench for crm_diag_seq.
// Main instance uses HOLD_CYC=2 with a CRM board model on the diag bus;
// two extra instances (HOLD_CYC=1 and 15) cover strobe width and latency.

module tb_crm_diag_seq;

  localparam int W    = 84;
  localparam int SW   = 12;
  localparam int NS   = 7;
  localparam int HOLD = 2;
  localparam int TW   = 16;   // transaction record: {is_load, func, data}
  localparam int MAXC = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- main DUT ----------------
  logic          req;
  logic [1:0]    op;
  logic [10:0]   adr;
  logic [W-1:0]  wdata;
  logic          busy, done, err;
  logic [W-1:0]  rdata;
  logic          lds, rds;
  logic [2:0]    func;
  logic [SW-1:0] ebus_out, ebus_in;
  logic [2:0]    state_dbg;

  crm_diag_seq #(.WORD_W(W), .SLICE_W(SW), .N_SLICES(NS), .HOLD_CYC(HOLD)) dut (
    .clk_crm_00_h(clk), .mr_reset_01_h(rst), .req_h(req), .op_h(op),
    .adr_h(adr), .wdata_h(wdata), .busy_h(busy), .done_h(done), .err_h(err),
    .rdata_h(rdata), .diag_load_strobe_h(lds), .diag_read_strobe_h(rds),
    .diag_func_h(func), .ebus_out_h(ebus_out), .ebus_in_h(ebus_in),
    .state_dbg(state_dbg)
  );

  // ---------------- alternate-hold DUTs ----------------
  logic          req_a [2];
  logic          busy_a [2], done_a [2], err_a [2], lds_a [2], rds_a [2];
  logic [W-1:0]  rdata_a [2];
  logic [2:0]    func_a [2], sd_a [2];
  logic [SW-1:0] eo_a [2];
  logic [1:0]    op_alt;
  logic [10:0]   adr_alt;
  logic [W-1:0]  wdata_alt;

  crm_diag_seq #(.WORD_W(W), .SLICE_W(SW), .N_SLICES(NS), .HOLD_CYC(1)) dut_h1 (
    .clk_crm_00_h(clk), .mr_reset_01_h(rst), .req_h(req_a[0]), .op_h(op_alt),
    .adr_h(adr_alt), .wdata_h(wdata_alt), .busy_h(busy_a[0]), .done_h(done_a[0]),
    .err_h(err_a[0]), .rdata_h(rdata_a[0]), .diag_load_strobe_h(lds_a[0]),
    .diag_read_strobe_h(rds_a[0]), .diag_func_h(func_a[0]), .ebus_out_h(eo_a[0]),
    .ebus_in_h(12'h000), .state_dbg(sd_a[0])
  );

  crm_diag_seq #(.WORD_W(W), .SLICE_W(SW), .N_SLICES(NS), .HOLD_CYC(15)) dut_h15 (
    .clk_crm_00_h(clk), .mr_reset_01_h(rst), .req_h(req_a[1]), .op_h(op_alt),
    .adr_h(adr_alt), .wdata_h(wdata_alt), .busy_h(busy_a[1]), .done_h(done_a[1]),
    .err_h(err_a[1]), .rdata_h(rdata_a[1]), .diag_load_strobe_h(lds_a[1]),
    .diag_read_strobe_h(rds_a[1]), .diag_func_h(func_a[1]), .ebus_out_h(eo_a[1]),
    .ebus_in_h(12'h000), .state_dbg(sd_a[1])
  );

  // ---------------- CRM board model ----------------
  // mode 0: read returns 0x100+func; mode 1: echoes stored word;
  // mode 2: echoes stored word with bit 83 stuck at 0.
  logic [W-1:0] board_mem [2048];
  logic [10:0]  board_adr;
  int           board_mode;
  logic [W-1:0] board_word;

  always @(posedge clk) begin
    if (lds) begin
      if (func == 3'd7) board_adr <= ebus_out[10:0];
      else board_mem[board_adr][SW*func +: SW] <= ebus_out;
    end
  end

  always_comb begin
    board_word = board_mem[board_adr];
    if (board_mode == 2) board_word[W-1] = 1'b0;
    ebus_in = 12'h000;
    if (board_mode == 0) ebus_in = 12'h100 + 12'(func);
    else if (func < 3'd7) ebus_in = board_word[SW*func +: SW];
  end

  // ---------------- scoreboard / reference model ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] obs_q[$];
  logic [W-1:0]  mem_ref [2048];

  logic          ld_t [MAXC+2];
  logic          rd_t [MAXC+2];
  logic [2:0]    fn_t [MAXC+2];
  logic [SW-1:0] eo_t [MAXC+2];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Expected bus transactions for one request, straight from the op rules.
  task automatic build_exp(input logic [1:0] o, input logic [10:0] a, input logic [W-1:0] d);
    exp_q.delete();
    exp_q.push_back({1'b1, 3'd7, 1'b0, a});
    if (o == 2'b00 || o == 2'b10) begin
      for (int i = 0; i < NS; i++) exp_q.push_back({1'b1, 3'(i), d[SW*i +: SW]});
    end
    if (o == 2'b10) exp_q.push_back({1'b1, 3'd7, 1'b0, a});
    if (o != 2'b00) begin
      for (int i = 0; i < NS; i++) exp_q.push_back({1'b0, 3'(i), 12'h000});
    end
  endtask

  function automatic logic [W-1:0] model_read(input logic [10:0] a, input int mode);
    logic [W-1:0] r;
    r = '0;
    if (mode == 0) begin
      for (int i = 0; i < NS; i++) r[SW*i +: SW] = 12'h100 + 12'(i);
    end else begin
      r = mem_ref[a];
      if (mode == 2) r[W-1] = 1'b0;
    end
    return r;
  endfunction

  // ---------------- driver: one request, trace, compare sequence ----------------
  task automatic run_op(input logic [1:0] o, input logic [10:0] a, input logic [W-1:0] d,
                        input int mode, input bit noise, output int lat,
                        output logic [W-1:0] rd_got, output logic e_got);
    int exp_lat, i, w;
    logic kind;
    bit stable;
    board_mode = mode;
    build_exp(o, a, d);
    exp_lat = exp_q.size() * (HOLD + 1) + 1 + ((o == 2'b10) ? 1 : 0);
    lat = 0;
    rd_got = '0;
    e_got = 1'b0;
    obs_q.delete();
    @(negedge clk);
    req = 1'b1; op = o; adr = a; wdata = d;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      ld_t[c] = lds; rd_t[c] = rds; fn_t[c] = func; eo_t[c] = ebus_out;
      if (c == 1) begin
        chk("busy_rise", busy, 1);
        chk("adr_strobe_start", lds, 1);
      end
      if (done) begin
        lat = c;
        rd_got = rdata;
        e_got = err;
        chk("busy_at_done", busy, 1);
        break;
      end
      if (noise && c < exp_lat - 1) begin
        req = 1'($urandom_range(0, 1));
        op = 2'($urandom_range(0, 3));
        adr = 11'($urandom_range(0, 2047));
        wdata = W'({$urandom(), $urandom(), $urandom()});
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
    chk("latency", lat, exp_lat);
    if (lat == 0) return;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_fall", busy, 0);
    // Split the trace into transactions and check each one's shape.
    i = 1;
    while (i < lat) begin
      if (ld_t[i] && rd_t[i]) chk("strobe_overlap", 1, 0);
      if (!ld_t[i] && !rd_t[i]) begin
        i++;
        continue;
      end
      kind = ld_t[i];
      w = 0;
      while (i + w < lat && (kind ? ld_t[i+w] : rd_t[i+w])) w++;
      chk("strobe_width", w, HOLD);
      chk("gap_low", {ld_t[i+w], rd_t[i+w]}, 0);
      stable = 1'b1;
      for (int k = 0; k <= w; k++) begin
        if (fn_t[i+k] !== fn_t[i]) stable = 1'b0;
        if (kind && eo_t[i+k] !== eo_t[i]) stable = 1'b0;
      end
      chk("txn_stable", stable, 1);
      obs_q.push_back({kind, fn_t[i], kind ? eo_t[i] : 12'h000});
      i = i + w + 1;
    end
    chk("txn_count", obs_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      chk("txn", obs_q[j], exp_q[j]);
    end
  endtask

  // Load on an alternate-hold DUT: latency plus strobe width / gap shape.
  task automatic run_alt(input int k, input int hold);
    int lat, runs, bad, w;
    lat = 0; runs = 0; bad = 0; w = 0;
    op_alt = 2'b00; adr_alt = 11'h155; wdata_alt = 84'h0123456789ABCDEF01234;
    @(negedge clk);
    req_a[k] = 1'b1;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      req_a[k] = 1'b0;
      ld_t[c] = lds_a[k];
      if (rds_a[k]) bad++;
      if (done_a[k]) begin
        lat = c;
        break;
      end
    end
    chk($sformatf("alt%0d_latency", hold), lat, 8 * (hold + 1) + 1);
    for (int c = 1; c < lat; c++) begin
      if (ld_t[c]) w++;
      else if (w != 0) begin
        runs++;
        if (w != hold) bad++;
        if (c + 1 < lat && !ld_t[c+1]) bad++;   // gap longer than one cycle
        w = 0;
      end
    end
    chk($sformatf("alt%0d_runs", hold), runs, 8);
    chk($sformatf("alt%0d_shape_errs", hold), bad, 0);
    chk($sformatf("alt%0d_err", hold), err_a[k], 0);
    @(negedge clk);
    chk($sformatf("alt%0d_idle", hold), sd_a[k], 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]   op;
    logic [10:0]  adr;
    logic [W-1:0] wdata;
    int           mode;
    int           exp_lat;
    logic         exp_err;
    logic [W-1:0] exp_rdata;
    bit           chk_rd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat;
    logic [W-1:0] rd_got, exp_rd, d;
    logic e_got;
    logic [1:0] o;
    logic [10:0] a;
    int mode;
    int done_cnt;
    int done_at [$];
    logic busy_26, busy_27;
    logic [SW-1:0] slice_lit [7];

    slice_lit = '{12'h345, 12'h012, 12'hDEF, 12'hABC, 12'h789, 12'h456, 12'h123};
    vecs[0] = '{2'b00, 11'h5A5, 84'h123456789ABCDEF012345, 1, 25, 1'b0, 84'h0, 1'b0};
    vecs[1] = '{2'b01, 11'h7FF, 84'h0, 0, 25, 1'b0, 84'h106105104103102101100, 1'b1};
    vecs[2] = '{2'b01, 11'h5A5, 84'h0, 1, 25, 1'b0, 84'h123456789ABCDEF012345, 1'b1};
    vecs[3] = '{2'b10, 11'h2A3, 84'h8F00FF00FF00FF00FF00F, 1, 50, 1'b0, 84'h8F00FF00FF00FF00FF00F, 1'b1};
    vecs[4] = '{2'b10, 11'h013, 84'h8A5A5A5A5A5A5A5A5A5A5, 2, 50, 1'b1, 84'h0A5A5A5A5A5A5A5A5A5A5, 1'b1};
    vecs[5] = '{2'b11, 11'h013, 84'h0, 1, 25, 1'b0, 84'h8A5A5A5A5A5A5A5A5A5A5, 1'b1};

    for (int i = 0; i < 2048; i++) begin
      board_mem[i] = '0;
      mem_ref[i] = '0;
    end
    board_adr = '0;
    board_mode = 1;
    req = 1'b0; op = '0; adr = '0; wdata = '0;
    req_a[0] = 1'b0; req_a[1] = 1'b0;
    op_alt = '0; adr_alt = '0; wdata_alt = '0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_strobes", {lds, rds}, 0);
    chk("rst_func", func, 0);
    chk("rst_ebus_out", ebus_out, 0);
    chk("rst_state", state_dbg, 0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven vectors
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].op == 2'b00 || vecs[v].op == 2'b10) mem_ref[vecs[v].adr] = vecs[v].wdata;
      run_op(vecs[v].op, vecs[v].adr, vecs[v].wdata, vecs[v].mode, 1'b0, lat, rd_got, e_got);
      chk($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
      chk($sformatf("vec%0d_err", v), e_got, vecs[v].exp_err);
      if (vecs[v].chk_rd) chk($sformatf("vec%0d_rdata", v), rd_got, vecs[v].exp_rdata);
      if (v == 0) begin
        chk("vec0_adr_data", obs_q.size() > 0 ? obs_q[0][11:0] : 12'hFFF, 12'h5A5);
        for (int s = 0; s < 7; s++) begin
          chk($sformatf("vec0_slice%0d", s),
              obs_q.size() > s + 1 ? obs_q[s+1][11:0] : 12'hFFF, slice_lit[s]);
        end
      end
    end

    // reset during WR slice 3 of a load
    board_mode = 1;
    @(negedge clk);
    req = 1'b1; op = 2'b00; adr = 11'h000; wdata = 84'hFFFFFFFFFFFFFFFFFFFFF;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      req = 1'b0;
    end
    chk("pre_rst_slice3", {lds, func}, {1'b1, 3'd3});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_strobes", {lds, rds}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_state", state_dbg, 0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("no_done_after_rst", done_cnt, 0);
    d = 84'h0C0FFEE0BADF00D123456;
    mem_ref[0] = d;
    run_op(2'b00, 11'h000, d, 1, 1'b0, lat, rd_got, e_got);
    run_op(2'b01, 11'h000, 84'h0, 1, 1'b0, lat, rd_got, e_got);
    chk("post_rst_readback", rd_got, d);

    // req held high: back-to-back reads, each accepted right after done
    board_mode = 0;
    done_at.delete();
    busy_26 = 1'b1; busy_27 = 1'b0;
    @(negedge clk);
    req = 1'b1; op = 2'b01; adr = 11'h7FF;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done) done_at.push_back(c);
      if (c == 26) busy_26 = busy;
      if (c == 27) busy_27 = busy;
      if (c == 77) req = 1'b0;
    end
    chk("b2b_done_count", done_at.size(), 3);
    chk("b2b_done0", done_at.size() > 0 ? done_at[0] : 0, 25);
    chk("b2b_done1", done_at.size() > 1 ? done_at[1] : 0, 51);
    chk("b2b_done2", done_at.size() > 2 ? done_at[2] : 0, 77);
    chk("b2b_idle_gap", busy_26, 0);
    chk("b2b_reaccept", busy_27, 1);
    chk("b2b_stopped", busy, 0);

    // randomized requests against the reference model, with req noise
    for (int k = 0; k < 20; k++) begin
      o = 2'($urandom_range(0, 3));
      a = 11'($urandom_range(0, 2047));
      d = W'({$urandom(), $urandom(), $urandom()});
      mode = (o == 2'b10) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      if (o == 2'b00 || o == 2'b10) mem_ref[a] = d;
      exp_rd = model_read(a, mode);
      run_op(o, a, d, mode, 1'($urandom_range(0, 1)), lat, rd_got, e_got);
      if (o != 2'b00) chk("rnd_rdata", rd_got, exp_rd);
      chk("rnd_err", e_got, (o == 2'b10) && (exp_rd != d));
    end

    // HOLD_CYC = 1 and 15
    run_alt(0, 1);
    run_alt(1, 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
